// File: rtl/apb2mem_bridge_if.sv
// APB3 bus bundle for apb2mem_bridge.
// master: the APB requester (e.g. periph_bus_wrap slot), slave: the bridge.
interface apb2mem_bridge_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [31:0]               pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [31:0]               prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb2mem_bridge.sv
// apb2mem_bridge: APB3 responder that issues one single-beat transaction on a
// req/gnt/rvalid memory port per APB transfer, holding pready low until the
// memory response returns. pready/pslverr/prdata are registered, high only in DONE.
// Optional watchdog: define APB2MEM_TIMEOUT_EN to abort stuck transfers after
// TIMEOUT_CYCLES cycles in REQ+RESP and swallow the orphaned response.
module apb2mem_bridge #(
    parameter int unsigned                APB_ADDR_WIDTH = 12,
    parameter int unsigned                MEM_ADDR_WIDTH = 32,
    parameter logic [MEM_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter int unsigned                TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    apb2mem_bridge_if.slave           apb,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i,
    input  logic                      mem_err_i
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e                    state_q, state_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic [31:0]               prdata_q, prdata_d;

    logic                      setup;
    logic                      unaligned;
    logic [MEM_ADDR_WIDTH-1:0] word_addr;
    logic                      timeout_hit;
    logic                      rvalid_ok;

    assign setup     = apb.psel && !apb.penable;
    assign unaligned = (apb.paddr[1:0] != 2'b00);
    // Carry out of the add is dropped so the window wraps at MEM_ADDR_WIDTH.
    assign word_addr = BASE_ADDR
                     + MEM_ADDR_WIDTH'({apb.paddr[APB_ADDR_WIDTH-1:2], 2'b00});

`ifdef APB2MEM_TIMEOUT_EN
    localparam int unsigned CntWRaw = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CntW    = (CntWRaw < 8) ? 8 : ((CntWRaw > 32) ? 32 : CntWRaw);
    // Fires in the TIMEOUT_CYCLES-th cycle spent in REQ+RESP.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drain_q, drain_d;

    assign timeout_hit = (cnt_q >= CntLast);
    // A response owed to an aborted transfer must never complete a newer one.
    assign rvalid_ok   = mem_rvalid_i && !drain_q;

    // Watchdog counter and drain flag next-state.
    always_comb begin
        cnt_d   = cnt_q;
        drain_d = drain_q;
        if (drain_q && mem_rvalid_i) begin
            drain_d = 1'b0;
        end
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StReq || state_q == StResp) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == StResp && timeout_hit && !rvalid_ok) begin
            drain_d = 1'b1;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign rvalid_ok          = mem_rvalid_i;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Transfer FSM next-state and registered-output next values.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            StIdle: begin
                if (setup) begin
                    addr_d  = word_addr;
                    we_d    = apb.pwrite;
                    wdata_d = apb.pwdata;
                    if (unaligned) begin
                        state_d   = StDone;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d = StReq;
                        req_d   = 1'b1;
                    end
                end
            end
            StReq: begin
                // A grant wins over the watchdog: once accepted, a response is owed.
                if (mem_gnt_i) begin
                    state_d = StResp;
                    req_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d   = StDone;
                    req_d     = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end
            end
            StResp: begin
                if (rvalid_ok) begin
                    state_d   = StDone;
                    pready_d  = 1'b1;
                    pslverr_d = mem_err_i;
                    prdata_d  = (!we_q && !mem_err_i) ? mem_rdata_i : 32'h0;
                end else if (timeout_hit) begin
                    state_d   = StDone;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = 4'hF;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb2mem_bridge.sv
// Testbench for apb2mem_bridge: directed transfers, a transaction-level model of
// when pready/mem_req must appear and with what values, and a per-cycle compare.
module tb_apb2mem_bridge;
    localparam int unsigned AW    = 12;
    localparam int          TO    = 8;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          NEVER = 1000000;
    localparam logic [31:0] STALE = 32'hFFFF_0000;
`ifdef APB2MEM_TIMEOUT_EN
    localparam int STALL_G = 4;
`else
    localparam int STALL_G = 5;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    apb2mem_bridge_if #(.APB_ADDR_WIDTH(AW)) apb_if ();

    apb2mem_bridge #(
        .APB_ADDR_WIDTH (AW),
        .MEM_ADDR_WIDTH (32),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .apb          (apb_if),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model: absolute cycle windows and values the DUT must show.
    int          exp_req_lo = 1;
    int          exp_req_hi = 0;
    int          exp_done   = -1;
    logic        exp_err    = 1'b0;
    logic        exp_we     = 1'b0;
    logic [31:0] exp_rdata  = '0;
    logic [31:0] exp_addr   = '0;
    logic [31:0] exp_wdata  = '0;
    bit          drain_pend = 1'b0;

    // Observations used for hand-computed literal checks.
    int          req_cnt = 0;
    int          cap_done = -1;
    logic [31:0] cap_addr, cap_wdata, cap_rdata;
    logic        cap_we, cap_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clock) begin
        bit er, ed;
        if (chk_en) begin
            er = (cyc >= exp_req_lo) && (cyc <= exp_req_hi);
            ed = (cyc == exp_done);
            chk("mem_req_o", 32'(mem_req_o), 32'(er));
            chk("mem_be_o", 32'(mem_be_o), 32'hF);
            if (er) begin
                chk("mem_addr_o", mem_addr_o, exp_addr);
                chk("mem_we_o", 32'(mem_we_o), 32'(exp_we));
                chk("mem_wdata_o", mem_wdata_o, exp_wdata);
            end
            chk("pready", 32'(apb_if.pready), 32'(ed));
            chk("pslverr", 32'(apb_if.pslverr), ed ? 32'(exp_err) : 32'h0);
            chk("prdata", apb_if.prdata, ed ? exp_rdata : 32'h0);
            if (mem_req_o === 1'b1) req_cnt++;
            if (mem_req_o === 1'b1 && mem_gnt_i) begin
                cap_addr  = mem_addr_o;
                cap_wdata = mem_wdata_o;
                cap_we    = mem_we_o;
            end
            if (apb_if.pready === 1'b1) begin
                cap_done  = cyc;
                cap_rdata = apb_if.prdata;
                cap_err   = apb_if.pslverr;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        mem_gnt_i      = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = '0;
        mem_err_i      = 1'b0;
    endtask

    // One APB transfer plus scripted memory responder. g: cycles of stall before
    // gnt (-1 never), r: cycles from gnt to rvalid (-1 never), rst_k: cycle offset
    // holding reset (0 none), stale_r: extra early rvalid offset from gnt (0 none).
    task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input int g, input int r, input logic [31:0] rd, input logic me,
                        input int rst_k, input int stale_r, input bit drop,
                        output int t0);
        int t, done_k, req_k, last;
        bit stale_hit;
        t        = cyc;
        t0       = t;
        req_cnt  = 0;
        cap_done = -1;
        apb_if.psel    = 1'b1;
        apb_if.penable = 1'b0;
        apb_if.paddr   = a;
        apb_if.pwdata  = wd;
        apb_if.pwrite  = wr;
        exp_addr  = BASE + (32'(a) & 32'hFFFF_FFFC);
        exp_we    = wr;
        exp_wdata = wd;
        stale_hit = (stale_r > 0) && !drain_pend;
        if (stale_r > 0) drain_pend = 1'b0;
        if (a[1:0] != 2'b00) begin
            done_k = 1; req_k = 0; exp_err = 1'b1; exp_rdata = '0;
        end else begin
            req_k = (g >= 0) ? 1 + g : NEVER;
            if (stale_hit) begin
                done_k = 2 + g + stale_r; exp_err = 1'b0; exp_rdata = wr ? 32'h0 : STALE;
            end else if (g >= 0 && r >= 1) begin
                done_k = 2 + g + r; exp_err = me; exp_rdata = (wr || me) ? 32'h0 : rd;
            end else begin
                done_k = NEVER; exp_err = 1'b0; exp_rdata = '0;
            end
`ifdef APB2MEM_TIMEOUT_EN
            if (done_k > TO + 1) begin
                done_k = TO + 1; exp_err = 1'b1; exp_rdata = '0;
                if (req_k > TO) req_k = TO;
                else drain_pend = 1'b1;
            end
`endif
            if (rst_k > 0) begin
                if (req_k > rst_k) req_k = rst_k;
                if (done_k > rst_k) done_k = -1;
                drain_pend = 1'b0;
            end
        end
        exp_req_lo = t + 1;
        exp_req_hi = t + req_k;
        exp_done   = (done_k > 0) ? t + done_k : -1;
        last       = (done_k > 0) ? done_k : rst_k + 1;
        for (int k = 1; k <= last; k++) begin
            tick();
            apb_if.penable = 1'b1;
            if (drop && k >= 2) begin
                apb_if.psel    = 1'b0;
                apb_if.penable = 1'b0;
            end
            mem_gnt_i    = (g >= 0) && (k == 1 + g);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            mem_err_i    = 1'b0;
            if (g >= 0 && r >= 1 && k == 1 + g + r) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = rd; mem_err_i = me;
            end
            if (g >= 0 && stale_r > 0 && k == 1 + g + stale_r) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = STALE;
            end
            reset = (rst_k > 0) && (k == rst_k);
        end
        tick();
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic stray_rvalid(input logic [31:0] d);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        drain_pend   = 1'b0;
        tick();
    endtask

    initial begin
        int t0;
        idle_inputs();
        apb_if.paddr  = '0;
        apb_if.pwdata = '0;
        apb_if.pwrite = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        tick();
        chk("rst mem_addr_o", mem_addr_o, 32'h0);
        chk("rst mem_wdata_o", mem_wdata_o, 32'h0);
        chk("rst mem_we_o", 32'(mem_we_o), 32'h0);
        reset = 1'b0;
        tick();

        // Minimum-latency write.
        xfer(1'b1, 12'h010, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0, 0, 0, 1'b0, t0);
        chk("wr latency", 32'(cap_done - t0), 32'd3);
        chk("wr addr", cap_addr, 32'h1000_0010);
        chk("wr wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("wr we", 32'(cap_we), 32'h1);
        chk("wr pslverr", 32'(cap_err), 32'h0);
        chk("wr req cycles", 32'(req_cnt), 32'd1);

        // Read with grant and response stalls.
        xfer(1'b0, 12'hFFC, 32'h0, STALL_G, 3, 32'h1234_5678, 1'b0, 0, 0, 1'b0, t0);
        chk("stall req cycles", 32'(req_cnt), 32'(STALL_G + 1));
        chk("stall latency", 32'(cap_done - t0), 32'(STALL_G + 5));
        chk("stall addr", cap_addr, 32'h1000_0FFC);
        chk("stall prdata", cap_rdata, 32'h1234_5678);

        // Unaligned: no memory access, immediate error.
        xfer(1'b0, 12'h013, 32'h0, -1, -1, 32'h0, 1'b0, 0, 0, 1'b0, t0);
        chk("unal req cycles", 32'(req_cnt), 32'd0);
        chk("unal latency", 32'(cap_done - t0), 32'd1);
        chk("unal pslverr", 32'(cap_err), 32'h1);
        chk("unal prdata", cap_rdata, 32'h0);

        // Memory error, then a stray response in IDLE.
        xfer(1'b0, 12'h020, 32'h0, 1, 2, 32'hA5A5_A5A5, 1'b1, 0, 0, 1'b0, t0);
        chk("merr latency", 32'(cap_done - t0), 32'd5);
        chk("merr pslverr", 32'(cap_err), 32'h1);
        chk("merr prdata", cap_rdata, 32'h0);
        stray_rvalid(32'h5555_AAAA);

        // Reset while waiting in RESP, late response, then a clean write.
        xfer(1'b0, 12'h030, 32'h0, 0, -1, 32'h0, 1'b0, 3, 0, 1'b0, t0);
        chk("rst no pready", 32'(cap_done), 32'hFFFF_FFFF);
        stray_rvalid(32'h7777_7777);
        xfer(1'b1, 12'h040, 32'hCAFE_F00D, 0, 1, 32'h0, 1'b0, 0, 0, 1'b0, t0);
        chk("post-rst latency", 32'(cap_done - t0), 32'd3);
        chk("post-rst addr", cap_addr, 32'h1000_0040);

        // Master drops psel/penable mid-transfer; completion still happens.
        xfer(1'b0, 12'h044, 32'h0, 1, 1, 32'h0BAD_F00D, 1'b0, 0, 0, 1'b1, t0);
        chk("drop latency", 32'(cap_done - t0), 32'd4);
        chk("drop prdata", cap_rdata, 32'h0BAD_F00D);

        // Lowest address.
        xfer(1'b0, 12'h000, 32'h0, 0, 1, 32'h0000_0001, 1'b0, 0, 0, 1'b0, t0);
        chk("addr0", cap_addr, 32'h1000_0000);
        chk("addr0 prdata", cap_rdata, 32'h0000_0001);

`ifdef APB2MEM_TIMEOUT_EN
        // No grant ever: abort after TO cycles in REQ.
        xfer(1'b0, 12'h050, 32'h0, -1, -1, 32'h0, 1'b0, 0, 0, 1'b0, t0);
        chk("to req cycles", 32'(req_cnt), 32'd8);
        chk("to latency", 32'(cap_done - t0), 32'd9);
        chk("to pslverr", 32'(cap_err), 32'h1);
        // Granted but no response: abort in RESP, the next read sees a stale rvalid.
        xfer(1'b0, 12'h054, 32'h0, 0, -1, 32'h0, 1'b0, 0, 0, 1'b0, t0);
        chk("to2 latency", 32'(cap_done - t0), 32'd9);
        chk("to2 pslverr", 32'(cap_err), 32'h1);
        xfer(1'b0, 12'h058, 32'h0, 0, 3, 32'h1111_2222, 1'b0, 0, 1, 1'b0, t0);
        chk("drain prdata", cap_rdata, 32'h1111_2222);
        chk("drain latency", 32'(cap_done - t0), 32'd5);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb2mem_bridge.md
Name: apb2mem_bridge

Overview:
APB3 slave (responder) that turns peripheral-bus accesses into single-beat transactions on a req/gnt/rvalid memory port, the same handshake style the core uses for its data port.
Sits on a free periph_bus_wrap master slot, for example behind the AXI2APB bridge, so software can reach a scratch RAM or memory-mapped IP through the APB space.
Serves exactly one transfer at a time and inserts APB wait states until the memory response returns.

Parameters:
APB_ADDR_WIDTH, 12, APB address width (4 KB slave window)
MEM_ADDR_WIDTH, 32, memory-side address width
BASE_ADDR, 32'h0000_0000, offset added to the word-aligned APB address
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with APB2MEM_TIMEOUT_EN

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
paddr  in  APB_ADDR_WIDTH  APB address
pwdata  in  32  APB write data
pwrite  in  1  1 = write
psel  in  1  slave select
penable  in  1  access phase
prdata  out  32  read data
pready  out  1  transfer complete
pslverr  out  1  transfer error
mem_req_o  out  1  memory request
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  response valid, for reads and writes
mem_we_o  out  1  write enable
mem_be_o  out  4  byte enable, always 4'hF
mem_addr_o  out  MEM_ADDR_WIDTH  word address
mem_wdata_o  out  32  write data
mem_rdata_i  in  32  read data
mem_err_i  in  1  error, sampled with mem_rvalid_i

Behaviour:
- Reset state: reset is sampled on the rising edge of clock. It forces:
  - FSM to IDLE;
  - prdata=0, pready=0, pslverr=0;
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=4'hF.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On psel=1 and penable=0 (setup phase), latch paddr, pwdata and pwrite.
  - If paddr[1:0]!=0: go to DONE with err=1. No memory access is made.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o=1. Address, write enable and write data stay stable until grant.
  - mem_addr_o = BASE_ADDR + {paddr[APB_ADDR_WIDTH-1:2],2'b00}, truncated to MEM_ADDR_WIDTH. Carry out of the addition is dropped (wrap-around).
  - On mem_gnt_i=1, drop mem_req_o in the next cycle and go to RESP.
- RESP:
  - mem_rvalid_i is accepted only in this state. rvalid seen in IDLE, REQ or DONE is ignored.
  - On rvalid: capture rdata (reads only), set err=mem_err_i, go to DONE.
- DONE:
  - pready=1 for exactly one cycle.
  - pslverr=err.
  - prdata = captured data; it is 0 on writes and on any error.
  - Next state is IDLE.
- Registered outputs: pready, pslverr and prdata are registered and are 0 outside DONE.
- Minimum latency: setup at cycle T, gnt at T+1, rvalid at T+2, pready at T+3. That is 2 wait states in the access phase.
- Ordering: gnt and rvalid in the same cycle is illegal for memory. rvalid is only accepted one or more cycles after gnt.
- Master protocol violation: if psel or penable drops mid-transfer, the memory transaction still completes. The DONE pulse is still issued and is not aborted.
- Reset mid-operation: FSM returns to IDLE and mem_req_o drops in the same edge. A late rvalid is ignored.

Optional Feature:
APB2MEM_TIMEOUT_EN
- Defined:
  - An 8..32-bit counter, sized $clog2(TIMEOUT_CYCLES+1), clears on entry to REQ and counts in REQ and RESP.
  - When it reaches TIMEOUT_CYCLES, go to DONE with pslverr=1 and prdata=0. mem_req_o is dropped.
  - If the timeout happens in RESP, a drain flag is set. It swallows the next mem_rvalid_i.
  - While the drain flag is set, a new transfer may enter REQ, but its RESP ignores rvalid until the drain flag clears.
- Undefined:
  - The bridge waits indefinitely for gnt and rvalid.
  - No counter or drain logic is built.

Test Plan:
- Write: setup paddr=12'h010, pwdata=32'hDEAD_BEEF, BASE_ADDR=32'h1000_0000; gnt at T+1, rvalid at T+2 -> mem_addr_o=32'h1000_0010, mem_we_o=1, mem_wdata_o=32'hDEAD_BEEF, be=4'hF; pready at T+3 with pslverr=0.
- Read with stalls: paddr=12'hFFC; gnt held low 5 cycles, rvalid 3 cycles after gnt with rdata=32'h1234_5678 -> mem_req_o held 6 cycles with stable address; single pready, prdata=32'h1234_5678.
- Unaligned: paddr=12'h013 -> mem_req_o never asserts; pready at T+1 with pslverr=1 and prdata=0.
- Memory error: read with rvalid and mem_err_i=1 -> pslverr=1, prdata=0. A stray rvalid in IDLE afterwards -> no pready.
- Reset mid-RESP: assert reset for 1 cycle while waiting for rvalid -> all outputs 0, FSM IDLE. Late rvalid ignored; next write completes normally.
- Timeout (APB2MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8): gnt never given -> pready with pslverr=1 after 8 cycles in REQ. Repeat with gnt given and no rvalid, then a late rvalid -> it is swallowed and the following read returns its own data.
